// File: rtl/mmu_pkg.sv
// Shared constants and types for the MMU page-map controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mmu_pkg;

  // I/O decode: block $D0-$DF, beeper/lock port $D1, map ports $D8-$DF
  localparam logic [3:0] MMU_IO_BASE       = 4'hD;
  localparam logic [7:0] MMU_BEEP_PORT     = 8'hD1;
  localparam logic [7:0] MMU_MAP_PORT_MASK = 8'hF8;

  // Default page map written after reset
  localparam logic [3:0] MMU_DEF_ENTRY0 = 4'd0;
  localparam logic [3:0] MMU_DEF_ENTRYN = 4'd1;

  typedef enum logic {INIT, RUN} mmu_state_e;

  // Default value for a given map entry
  function automatic logic [3:0] mmu_def_value(input logic [2:0] idx);
    return (idx == 3'd0) ? MMU_DEF_ENTRY0 : MMU_DEF_ENTRYN;
  endfunction

endpackage

// File: rtl/mmu_strobe_sync.sv
// Synchronizes Z80 IORQ/RD/WR into clk and flags the first cycle of each I/O cycle.
// Latency: SYNC_STAGES clk edges from stable strobe to event/level outputs.
// Backpressure: none; events are single-cycle pulses and are never held.
module mmu_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_iorq_n,
  input  logic i_rd_n,
  input  logic i_wr_n,
  output logic o_rd_act,
  output logic o_rd_evt,
  output logic o_wr_evt
);

  logic [SYNC_STAGES-1:0] r_iorq_sync;
  logic [SYNC_STAGES-1:0] r_rd_sync;
  logic [SYNC_STAGES-1:0] r_wr_sync;
  logic                   r_rd_act_d;
  logic                   r_wr_act_d;
  logic                   w_wr_act;

  // Synchronizer chains idle high (strobes inactive); previous-cycle activity for edge detect
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_iorq_sync <= '1;
      r_rd_sync   <= '1;
      r_wr_sync   <= '1;
      r_rd_act_d  <= 1'b0;
      r_wr_act_d  <= 1'b0;
    end else begin
      r_iorq_sync <= {r_iorq_sync[SYNC_STAGES-2:0], i_iorq_n};
      r_rd_sync   <= {r_rd_sync[SYNC_STAGES-2:0], i_rd_n};
      r_wr_sync   <= {r_wr_sync[SYNC_STAGES-2:0], i_wr_n};
      r_rd_act_d  <= o_rd_act;
      r_wr_act_d  <= w_wr_act;
    end
  end

  assign o_rd_act = ~r_iorq_sync[SYNC_STAGES-1] & ~r_rd_sync[SYNC_STAGES-1];
  assign w_wr_act = ~r_iorq_sync[SYNC_STAGES-1] & ~r_wr_sync[SYNC_STAGES-1];
  assign o_rd_evt = o_rd_act & ~r_rd_act_d;
  assign o_wr_evt = w_wr_act & ~r_wr_act_d;

endmodule

// File: rtl/mmu_map_ctrl.sv
// MMU page-map controller: I/O decode, lock protocol, default-map init and write-port arbiter.
// Latency: CPU map write hits map_we 1 cycle after the synced event; map readback 1 cycle registered.
// Backpressure: loader waits (ld_ack withheld) while INIT or a CPU write owns the write port.
module mmu_map_ctrl
  import mmu_pkg::*;
#(
  parameter logic [3:0]  IO_BASE        = MMU_IO_BASE,
  parameter int unsigned UNLOCK_TIMEOUT = 65535,
  parameter int          SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iorq_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [7:0] a,
  input  logic [3:0] din,
  output logic [7:0] dout,
  output logic       dout_en,
  input  logic       ld_req,
  input  logic [2:0] ld_adr,
  input  logic [3:0] ld_data,
  output logic       ld_ack,
  output logic       map_we,
  output logic [2:0] map_adr,
  output logic [3:0] map_data,
  input  logic [3:0] map_rdata,
  output logic       locked,
  output logic       beep,
  output logic       busy
);

  localparam int CNT_W = (UNLOCK_TIMEOUT > 0) ? $clog2(UNLOCK_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(UNLOCK_TIMEOUT);

  mmu_state_e       r_state, w_state_nxt;
  logic [2:0]       r_idx, w_idx_nxt;
  logic             r_locked, r_beep;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_pend_vld;
  logic [2:0]       r_pend_adr;
  logic [3:0]       r_pend_dat;
  logic             r_dout_en;
  logic [7:0]       r_dout;
  logic             w_rd_act, w_rd_evt, w_wr_evt;
  logic             w_map_port, w_beep_port, w_cpu_acc, w_map_rd, w_pend_issue;

  mmu_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_iorq_n (iorq_n),
    .i_rd_n   (rd_n),
    .i_wr_n   (wr_n),
    .o_rd_act (w_rd_act),
    .o_rd_evt (w_rd_evt),
    .o_wr_evt (w_wr_evt)
  );

  assign w_map_port  = (a & MMU_MAP_PORT_MASK) == {IO_BASE, 4'h8};
  assign w_beep_port = a == {IO_BASE, MMU_BEEP_PORT[3:0]};
  assign w_cpu_acc   = w_wr_evt & w_map_port & ~r_locked;
  assign w_map_rd    = w_rd_act & w_map_port;
  assign w_cnt_inc   = r_cnt + CNT_W'(1);

  // FSM state and init index register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= INIT;
      r_idx   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next state and write-port arbitration: INIT > pending CPU write > loader
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    map_we       = 1'b0;
    map_adr      = a[2:0];
    map_data     = 4'd0;
    ld_ack       = 1'b0;
    w_pend_issue = 1'b0;
    if (!reset) begin
      case (r_state)
        INIT: begin
          map_we    = 1'b1;
          map_adr   = r_idx;
          map_data  = mmu_def_value(r_idx);
          w_idx_nxt = r_idx + 3'd1;
          if (r_idx == 3'd7) w_state_nxt = RUN;
        end
        RUN: begin
          if (r_pend_vld) begin
            map_we       = 1'b1;
            map_adr      = r_pend_adr;
            map_data     = r_pend_dat;
            w_pend_issue = 1'b1;
          end else if (ld_req) begin
            map_we   = 1'b1;
            ld_ack   = 1'b1;
            map_adr  = ld_adr;
            map_data = ld_data;
          end
        end
        default: ;
      endcase
    end
  end

  // 1-deep CPU write register; a newer accepted write replaces one still waiting out INIT
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_vld <= 1'b0;
      r_pend_adr <= 3'd0;
      r_pend_dat <= 4'd0;
    end else if (w_cpu_acc) begin
      r_pend_vld <= 1'b1;
      r_pend_adr <= a[2:0];
      r_pend_dat <= din;
    end else if (w_pend_issue) begin
      r_pend_vld <= 1'b0;
    end
  end

  // Lock protocol, beeper toggle and inactivity auto-relock
  always_ff @(posedge clk) begin
    if (reset) begin
      r_locked <= 1'b1;
      r_beep   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (UNLOCK_TIMEOUT != 0 && !r_locked) begin
        if (w_cpu_acc) begin
          r_cnt <= '0;
        end else if (w_cnt_inc == CNT_MAX) begin
          r_locked <= 1'b1;
          r_cnt    <= '0;
        end else begin
          r_cnt <= w_cnt_inc;
        end
      end
      if (w_rd_evt && w_beep_port) begin
        r_locked <= 1'b0;
        r_cnt    <= '0;
      end
      if (w_wr_evt && w_beep_port) begin
        r_locked <= 1'b1;
        r_beep   <= ~r_beep;
      end
    end
  end

  // Registered map readback; data held while the write port borrows map_adr
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout_en <= 1'b0;
      r_dout    <= 8'd0;
    end else begin
      r_dout_en <= w_map_rd;
      if (!w_map_rd)    r_dout <= 8'd0;
      else if (!map_we) r_dout <= {4'b0, map_rdata};
    end
  end

  assign dout    = r_dout;
  assign dout_en = r_dout_en;
  assign locked  = r_locked;
  assign beep    = r_beep;
  assign busy    = (r_state == INIT);

endmodule

// File: doc/mmu_map_ctrl.md
Name: mmu_map_ctrl

Overview:
- Clocked controller that owns the 8-entry x 4-bit page-map register file of the MMU.
- Synchronizes Z80 I/O strobes and decodes ports $D0-$DF.
- Runs the lock/unlock protocol, a post-reset default-map init sequencer, and an arbiter that shares the map write port between the CPU and a loader requester (boot/debug).
- Drives a single write port plus a read address into the page register file.

Parameters:
- IO_BASE, 4'hD, upper nibble of the decoded I/O block.
- UNLOCK_TIMEOUT, 65535, clocks without an accepted CPU map write before auto-relock; 0 disables auto-relock.
- SYNC_STAGES, 2, synchronizer depth on iorq_n/rd_n/wr_n (minimum 2).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- iorq_n  in  1  Z80 IORQ, async to clk
- rd_n  in  1  Z80 RD, async
- wr_n  in  1  Z80 WR, async
- a  in  8  Z80 A7..A0
- din  in  4  Z80 D3..D0
- dout  out  8  read data to CPU bus
- dout_en  out  1  bus drive enable
- ld_req  in  1  loader write request (level)
- ld_adr  in  3  loader map entry
- ld_data  in  4  loader map value
- ld_ack  out  1  one-cycle grant pulse
- map_we  out  1  register-file write strobe
- map_adr  out  3  register-file address
- map_data  out  4  register-file write data
- map_rdata  in  4  register-file read data at map_adr (combinational)
- locked  out  1  1 = CPU map writes ignored
- beep  out  1  beeper toggle output
- busy  out  1  init sequence active

Behaviour:
- Reset values:
  - State INIT, init index 0, busy=1, locked=1, beep=0.
  - map_we=0, ld_ack=0, dout_en=0, dout=0.
  - Pending-write flag cleared, timeout counter 0.
- Sync and edge detect:
  - iorq_n, rd_n, wr_n each pass through SYNC_STAGES flops.
  - An I/O write event is the first cycle in which synchronized iorq_n=0 and wr_n=0 after either was high; a[7:0] and din are sampled in that cycle.
  - The I/O read event is detected the same way on rd_n.
- Decode:
  - Map port = a[7:4]==IO_BASE with a[3]=1 ($D8-$DF), entry = a[2:0].
  - Beep port = $D1.
- Lock protocol:
  - Read event on $D1 clears locked.
  - Write event on $D1 sets locked and toggles beep.
  - Auto-relock: locked sets when the counter reaches UNLOCK_TIMEOUT. The counter resets to 0 on unlock and on each accepted CPU map write.
- CPU map write:
  - A write event on $D8-$DF with locked=0 is accepted; with locked=1 it is dropped silently.
  - Accepted writes assert map_we for exactly 1 cycle, in the cycle after the event is detected: SYNC_STAGES+1 clk edges after the strobes are stable low.
- CPU map read:
  - While synchronized iorq_n=0, rd_n=0 and the port is $D8-$DF: dout_en=1, map_adr=a[2:0], dout={4'b0,map_rdata}.
  - This path is registered, so it has 1 cycle of latency after the synchronized condition.
  - dout_en drops 1 cycle after the condition ends.
- Arbiter (write port):
  - Priority order: INIT > CPU > loader.
  - The loader is granted only in a cycle with no CPU write and no INIT write. The grant drives map_we=1 and ld_ack=1 in that same cycle, using ld_adr/ld_data.
  - Loader writes ignore locked.
  - The loader must drop ld_req or present new data after ld_ack; a held ld_req re-arbitrates each cycle.
- INIT FSM, states INIT -> RUN:
  - INIT writes entry i per cycle for i=0..7: value 0 for entry 0, value 1 for entries 1-7.
  - After entry 7, go to RUN and set busy=0.
  - A CPU write accepted during INIT is held in a 1-deep pending register and issued in the first RUN cycle; a second one during INIT overwrites it.
  - ld_req is not acked during INIT.
- map_adr/map_data mux: the write source when map_we=1, otherwise the CPU read address.
- Reset asserted mid-operation: returns to INIT next cycle, pending write discarded, and the full default map is rewritten.

Decomposition:
- Shared package mmu_pkg holds:
  - Port constants MMU_IO_BASE, MMU_BEEP_PORT=8'hD1, MMU_MAP_PORT_MASK.
  - Default map values MMU_DEF_ENTRY0=4'd0, MMU_DEF_ENTRYN=4'd1.
  - A state enum {INIT, RUN}.
- One sub-module, mmu_strobe_sync, containing the synchronizer chain and edge detector for the three strobes. Instantiated once.

Test Plan:
- Init: deassert reset -> map_we pulses 8 consecutive cycles, adr 0..7, data 0,1,1,1,1,1,1,1; then busy=0, locked=1.
- Lock: while locked, write $DA=5 -> no map_we. Read $D1, then write $DA=5 -> single map_we, adr 2, data 5, SYNC_STAGES+1 edges after wr_n low. Write $D1 -> locked=1, beep toggles.
- Readback: unlocked, read $DC with map_rdata=4'h9 -> dout_en=1, map_adr=4, dout=8'h09; dout_en=0 one cycle after rd_n rises.
- Arbitration: ld_req held with adr 3, data 7, and a CPU write to $DB=2 landing in the same cycle -> CPU write first, ld_ack the next cycle (data 7).
- Pending write: unlocked, CPU writes $DF=4 during INIT -> map_we adr 7, data 4 in the first RUN cycle, after the default write to entry 7. No ld_ack during INIT.
- Timeout: UNLOCK_TIMEOUT=16, unlock, idle 16 clk -> locked=1; a later write to $D8 is dropped. Reset mid-INIT at index 4 -> sequence restarts at entry 0.
